// File: rtl/dispatch_queue_pkg.sv
// dispatch_queue_pkg: shared types and opcodes for the decode-to-RS dispatch queue
package dispatch_queue_pkg;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_FP    = 7'b1000011;
  typedef enum logic [1:0] {
    ALU           = 2'd0,
    Load          = 2'd1,
    Store         = 2'd2,
    FloatingPoint = 2'd3
  } FU;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
  } ID_RS_PACKET;
  typedef struct packed {
    ID_RS_PACKET pkt;
    FU           fu;
    logic        valid;
  } DQ_ENTRY;
endpackage

// File: rtl/dispatch_queue_if.sv
// dispatch_queue_if: decode-side and RS-side signals of the dispatch queue
interface dispatch_queue_if #(parameter int DEPTH = 8);
  import dispatch_queue_pkg::*;
  localparam int PTR_W = $clog2(DEPTH);
  ID_RS_PACKET    id_packet;
  logic           id_valid;
  logic           id_ready;
  logic           squash;
  logic [3:0]     rs_fu_free;
  ID_RS_PACKET    rs_packet;
  FU              rs_fu;
  logic           rs_valid;
  logic           rs_fire;
  logic [PTR_W:0] count;
  modport master (
    output id_packet, id_valid, squash, rs_fu_free,
    input  id_ready, rs_packet, rs_fu, rs_valid, rs_fire, count
  );
  modport slave (
    input  id_packet, id_valid, squash, rs_fu_free,
    output id_ready, rs_packet, rs_fu, rs_valid, rs_fire, count
  );
endinterface

// File: rtl/dispatch_queue_fu_classify.sv
// fu_classify: maps an instruction opcode to the functional-unit class it needs
module fu_classify
  import dispatch_queue_pkg::*;
(
  input  logic [6:0] opcode,
  output FU          fu
);
  // opcodes outside the three special classes all go to the ALU
  always_comb fu = (opcode == OPC_LOAD)  ? Load :
                   (opcode == OPC_STORE) ? Store :
                   (opcode == OPC_FP)    ? FloatingPoint : ALU;
endmodule

// File: rtl/dispatch_queue.sv
// dispatch_queue: in-order circular FIFO holding decoded packets until their RS class is free
module dispatch_queue
  import dispatch_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input logic             clock,
  input logic             reset,
  dispatch_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  DQ_ENTRY          mem [DEPTH];
  DQ_ENTRY          hd;
  logic [PTR_W-1:0] head, tail;
  logic [PTR_W:0]   cnt;
  FU                cls;
  logic             enq, deq;
  fu_classify u_classify (.opcode(bus.id_packet.inst[6:0]), .fu(cls));
  // head view: outputs are masked while the head slot is empty; id_ready looks only at registered count
  always_comb begin
    hd           = mem[head];
    bus.rs_valid = hd.valid;
    bus.rs_packet = hd.valid ? hd.pkt : '0;
    bus.rs_fu    = hd.valid ? hd.fu : ALU;
    bus.rs_fire  = hd.valid && bus.rs_fu_free[hd.fu];
    bus.id_ready = cnt < (PTR_W+1)'(DEPTH);
    bus.count    = cnt;
    enq          = bus.id_valid && bus.id_ready;
    deq          = bus.rs_fire;
  end
  // pointers, occupancy and entry storage; squash wins over enqueue and dequeue
  always_ff @(posedge clock or negedge reset) begin
    if (!reset || bus.squash) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (deq) begin
        mem[head].valid <= 1'b0;
        head            <= head + 1'b1;
      end
      if (enq) begin
        mem[tail] <= '{pkt: bus.id_packet, fu: cls, valid: 1'b1};
        tail      <= tail + 1'b1;
      end
      cnt <= cnt + (PTR_W+1)'(enq) - (PTR_W+1)'(deq);
    end
  end
endmodule
